// File: rtl/gameplay_datapath_if.sv
// Command/status bundle between the gameplay FSM (master) and its datapath (slave).
// The slave side also carries the position and redraw strobe consumed by the VGA stage.
interface gameplay_datapath_if;
    logic       ld_x;
    logic       ld_y;
    logic       enable;
    logic       inc_score;
    logic       dec_chances;
    logic [7:0] new_x_position;
    logic [6:0] new_y_position;
    logic       o;
    logic       c;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [7:0] prev_x;
    logic [3:0] score;
    logic [3:0] chances;
    logic       draw_req;

    modport master (
        output ld_x, ld_y, enable, inc_score, dec_chances, new_x_position, new_y_position,
        input  o, c, x_out, y_out, prev_x, score, chances, draw_req
    );

    modport slave (
        input  ld_x, ld_y, enable, inc_score, dec_chances, new_x_position, new_y_position,
        output o, c, x_out, y_out, prev_x, score, chances, draw_req
    );
endinterface

// File: rtl/gameplay_datapath.sv
// Gameplay datapath: sliding block position, placed-block x, score, chances and redraw strobe.
// Define GAMEPLAY_DP_SPEEDUP_EN to shorten the move period by SPEED_STEP per advanced row.
module gameplay_datapath #(
    parameter int unsigned X_MAX        = 160,
    parameter int unsigned BLOCK_W      = 16,
    parameter int unsigned BASE_Y       = 104,
    parameter int unsigned TICK_DIV     = 833333,
    parameter int unsigned SPEED_STEP   = 100000,
    parameter int unsigned INIT_CHANCES = 3
) (
    input  logic                clk,
    input  logic                resetn,
    gameplay_datapath_if.slave  bus
);

    localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0]  X_TURN  = 8'(X_MAX - BLOCK_W);
    localparam logic [6:0]  Y_BASE  = 7'(BASE_Y);
    localparam logic [3:0]  CH_INIT = 4'(INIT_CHANCES);
    localparam logic [8:0]  W9      = 9'(BLOCK_W);

    typedef enum logic {DirRight, DirLeft} dir_e;

    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [7:0]       prev_x_q, prev_x_d;
    dir_e             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       score_q, score_d;
    logic [3:0]       chances_q, chances_d;
    logic             draw_q, draw_d;
    logic [2:0]       level_q, level_d;

    logic [31:0]      limit;
    logic             tick;
    logic             restart;
    logic             advance;

`ifdef GAMEPLAY_DP_SPEEDUP_EN
    logic [31:0] slowdown;

    always_comb begin
        slowdown = 32'(level_q) * SPEED_STEP;
        limit    = (slowdown < TICK_DIV) ? (TICK_DIV - slowdown) : 32'd1;
    end
`else
    always_comb begin
        limit = TICK_DIV;
    end
`endif

    // >= rather than == so a limit that shrinks below the current count still wraps.
    assign tick    = (32'(div_q) >= (limit - 32'd1));
    assign restart = bus.ld_y && (bus.new_y_position == Y_BASE);
    assign advance = bus.ld_y && (bus.new_y_position != y_q) && !restart;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        prev_x_d  = prev_x_q;
        dir_d     = dir_q;
        div_d     = div_q;
        score_d   = score_q;
        chances_d = chances_q;
        level_d   = level_q;

        if (bus.ld_x) begin
            x_d   = bus.new_x_position;
            div_d = '0;
            dir_d = DirRight;
        end else if (bus.enable) begin
            if (tick) begin
                div_d = '0;
                if (x_q >= X_TURN) begin
                    dir_d = DirLeft;
                    x_d   = x_q - 8'd1;
                end else if (x_q == 8'd0) begin
                    dir_d = DirRight;
                    x_d   = 8'd1;
                end else if (dir_q == DirRight) begin
                    x_d = x_q + 8'd1;
                end else begin
                    x_d = x_q - 8'd1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (bus.ld_y) begin
            y_d = bus.new_y_position;
        end

        if (restart) begin
            score_d   = '0;
            chances_d = CH_INIT;
            level_d   = '0;
            prev_x_d  = '0;
        end else begin
            if (advance) begin
                prev_x_d = x_q;
                if (level_q != 3'd7) begin
                    level_d = level_q + 3'd1;
                end
            end
            if (bus.inc_score && (score_q != 4'd15)) begin
                score_d = score_q + 4'd1;
            end
            if (bus.dec_chances && (chances_q != 4'd0)) begin
                chances_d = chances_q - 4'd1;
            end
        end

        draw_d = (x_d != x_q) || (y_d != y_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q       <= '0;
            y_q       <= Y_BASE;
            prev_x_q  <= '0;
            dir_q     <= DirRight;
            div_q     <= '0;
            score_q   <= '0;
            chances_q <= CH_INIT;
            draw_q    <= 1'b0;
            level_q   <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            prev_x_q  <= prev_x_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
            score_q   <= score_d;
            chances_q <= chances_d;
            draw_q    <= draw_d;
            level_q   <= level_d;
        end
    end

    // 9-bit compare so x + BLOCK_W near 255 does not wrap.
    logic [8:0] x9, p9;
    assign x9 = {1'b0, x_q};
    assign p9 = {1'b0, prev_x_q};

    assign bus.o        = ((x9 + W9) > p9) && ((p9 + W9) > x9);
    assign bus.c        = (chances_q != 4'd0);
    assign bus.x_out    = x_q;
    assign bus.y_out    = y_q;
    assign bus.prev_x   = prev_x_q;
    assign bus.score    = score_q;
    assign bus.chances  = chances_q;
    assign bus.draw_req = draw_q;

endmodule

// File: tb/tb_gameplay_datapath.sv
// Directed bench for gameplay_datapath: vector table plus bounce, reset and speed sequences.
// Honours GAMEPLAY_DP_SPEEDUP_EN for the expected move period after two advances.
module tb_gameplay_datapath;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    gameplay_datapath_if dp();

    gameplay_datapath #(
        .X_MAX        (160),
        .BLOCK_W      (16),
        .BASE_Y       (104),
        .TICK_DIV     (4),
        .SPEED_STEP   (1),
        .INIT_CHANCES (3)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (dp)
    );

    // ctl = {ld_x, ld_y, enable, inc_score, dec_chances}; eocd = {o, c, draw_req}
    typedef struct {
        logic [4:0] ctl;
        logic [7:0] nx;
        logic [6:0] ny;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [7:0] ep;
        logic [3:0] es;
        logic [3:0] ec;
        logic [2:0] eocd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dp.ld_x           = 1'b0;
        dp.ld_y           = 1'b0;
        dp.enable         = 1'b0;
        dp.inc_score      = 1'b0;
        dp.dec_chances    = 1'b0;
        dp.new_x_position = 8'd0;
        dp.new_y_position = 7'd0;
    endtask

    task automatic wait_x(input logic [7:0] target, input int budget, output int n);
        n = 0;
        while ((dp.x_out != target) && (n < budget)) begin
            cyc();
            n++;
        end
    endtask

    int n;
    int t1, t144, t143, draws;
    int exp_period;

    initial begin
        vecs[0]  = '{5'b00000, 8'd0,   7'd0,   8'd0,   7'd104, 8'd0,   4'd0, 4'd3, 3'b110};
        vecs[1]  = '{5'b10000, 8'd40,  7'd0,   8'd40,  7'd104, 8'd0,   4'd0, 4'd3, 3'b011};
        vecs[2]  = '{5'b11000, 8'd0,   7'd88,  8'd0,   7'd88,  8'd40,  4'd0, 4'd3, 3'b011};
        vecs[3]  = '{5'b10000, 8'd25,  7'd0,   8'd25,  7'd88,  8'd40,  4'd0, 4'd3, 3'b111};
        vecs[4]  = '{5'b10000, 8'd24,  7'd0,   8'd24,  7'd88,  8'd40,  4'd0, 4'd3, 3'b011};
        vecs[5]  = '{5'b10000, 8'd56,  7'd0,   8'd56,  7'd88,  8'd40,  4'd0, 4'd3, 3'b011};
        vecs[6]  = '{5'b10000, 8'd55,  7'd0,   8'd55,  7'd88,  8'd40,  4'd0, 4'd3, 3'b111};
        vecs[7]  = '{5'b10000, 8'd55,  7'd0,   8'd55,  7'd88,  8'd40,  4'd0, 4'd3, 3'b110};
        vecs[8]  = '{5'b01011, 8'd0,   7'd88,  8'd55,  7'd88,  8'd40,  4'd1, 4'd2, 3'b110};
        vecs[9]  = '{5'b01011, 8'd0,   7'd88,  8'd55,  7'd88,  8'd40,  4'd2, 4'd1, 3'b110};
        vecs[10] = '{5'b01011, 8'd0,   7'd88,  8'd55,  7'd88,  8'd40,  4'd3, 4'd0, 3'b100};
        vecs[11] = '{5'b00001, 8'd0,   7'd0,   8'd55,  7'd88,  8'd40,  4'd3, 4'd0, 3'b100};
        vecs[12] = '{5'b00011, 8'd0,   7'd0,   8'd55,  7'd88,  8'd40,  4'd4, 4'd0, 3'b100};
        vecs[13] = '{5'b01010, 8'd0,   7'd104, 8'd55,  7'd104, 8'd0,   4'd0, 4'd3, 3'b011};
        vecs[14] = '{5'b10000, 8'd240, 7'd0,   8'd240, 7'd104, 8'd0,   4'd0, 4'd3, 3'b011};
        vecs[15] = '{5'b11000, 8'd250, 7'd88,  8'd250, 7'd88,  8'd240, 4'd0, 4'd3, 3'b111};
        vecs[16] = '{5'b01000, 8'd0,   7'd88,  8'd250, 7'd88,  8'd240, 4'd0, 4'd3, 3'b110};

        idle();
        resetn = 1'b0;
        #12;
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            dp.ld_x           = vecs[i].ctl[4];
            dp.ld_y           = vecs[i].ctl[3];
            dp.enable         = vecs[i].ctl[2];
            dp.inc_score      = vecs[i].ctl[1];
            dp.dec_chances    = vecs[i].ctl[0];
            dp.new_x_position = vecs[i].nx;
            dp.new_y_position = vecs[i].ny;
            cyc();
            chk($sformatf("v%0d x_out", i),    32'(dp.x_out),    32'(vecs[i].ex));
            chk($sformatf("v%0d y_out", i),    32'(dp.y_out),    32'(vecs[i].ey));
            chk($sformatf("v%0d prev_x", i),   32'(dp.prev_x),   32'(vecs[i].ep));
            chk($sformatf("v%0d score", i),    32'(dp.score),    32'(vecs[i].es));
            chk($sformatf("v%0d chances", i),  32'(dp.chances),  32'(vecs[i].ec));
            chk($sformatf("v%0d o", i),        32'(dp.o),        32'(vecs[i].eocd[2]));
            chk($sformatf("v%0d c", i),        32'(dp.c),        32'(vecs[i].eocd[1]));
            chk($sformatf("v%0d draw_req", i), 32'(dp.draw_req), 32'(vecs[i].eocd[0]));
        end
        idle();

        // Score saturates at 15.
        dp.inc_score = 1'b1;
        for (int i = 0; i < 17; i++) cyc();
        dp.inc_score = 1'b0;
        chk("score_sat", 32'(dp.score), 32'd15);

        // Bounce from x=0: one move per 4 cycles, turn at 144.
        dp.ld_x = 1'b1;
        dp.new_x_position = 8'd0;
        cyc();
        idle();
        dp.enable = 1'b1;
        t1 = -1; t144 = -1; t143 = -1; draws = 0;
        for (int i = 1; i <= 580; i++) begin
            cyc();
            if (dp.draw_req) draws++;
            if ((dp.x_out == 8'd1) && (t1 < 0)) t1 = i;
            if ((dp.x_out == 8'd144) && (t144 < 0)) t144 = i;
            if ((dp.x_out == 8'd143) && (t144 >= 0) && (t143 < 0)) t143 = i;
        end
        chk("first_move", 32'(t1), 32'd4);
        chk("reach_144", 32'(t144), 32'd576);
        chk("turn_143", 32'(t143), 32'd580);
        chk("draw_pulses", 32'(draws), 32'd145);

        // enable low freezes the block.
        dp.enable = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("freeze_x", 32'(dp.x_out), 32'd143);
        chk("freeze_draw", 32'(dp.draw_req), 32'd0);

        // Asynchronous reset mid-move with non-reset state present.
        dp.dec_chances = 1'b1;
        dp.ld_y = 1'b1;
        dp.new_y_position = 7'd72;
        cyc();
        idle();
        dp.enable = 1'b1;
        cyc();
        cyc();
        #3;
        resetn = 1'b0;
        #1;
        chk("rst x_out", 32'(dp.x_out), 32'd0);
        chk("rst y_out", 32'(dp.y_out), 32'd104);
        chk("rst prev_x", 32'(dp.prev_x), 32'd0);
        chk("rst score", 32'(dp.score), 32'd0);
        chk("rst chances", 32'(dp.chances), 32'd3);
        chk("rst c", 32'(dp.c), 32'd1);
        chk("rst draw_req", 32'(dp.draw_req), 32'd0);
        #2;
        resetn = 1'b1;
        wait_x(8'd1, 20, n);
        chk("move_after_reset", 32'(n), 32'd4);

        // Two advances, then measure the move period.
`ifdef GAMEPLAY_DP_SPEEDUP_EN
        exp_period = 2;
`else
        exp_period = 4;
`endif
        idle();
        dp.ld_y = 1'b1;
        dp.new_y_position = 7'd88;
        cyc();
        dp.new_y_position = 7'd72;
        cyc();
        idle();
        dp.ld_x = 1'b1;
        dp.new_x_position = 8'd0;
        cyc();
        idle();
        dp.enable = 1'b1;
        wait_x(8'd1, 20, n);
        chk("speed_period1", 32'(n), 32'(exp_period));
        wait_x(8'd2, 20, n);
        chk("speed_period2", 32'(n), 32'(exp_period));
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gameplay_datapath.md
# gameplay_datapath

Datapath slave of the gameplay FSM. It holds the sliding block's x/y position, the x of the block placed on the row below, the score and the remaining chances. It returns the overlap flag `o` and the chances-remaining flag `c` to the FSM, and drives the position plus a redraw strobe to the VGA drawing stage.

## Interface
Parameters:
- `X_MAX`, 160: screen width in pixels.
- `BLOCK_W`, 16: block width in pixels.
- `BASE_Y`, 104: y of the bottom row. A load to this row restarts the game.
- `TICK_DIV`, 833333: clock cycles per 1-pixel move (60 px/s at 50 MHz).
- `SPEED_STEP`, 100000: divider reduction per row advanced (see Configuration).
- `INIT_CHANCES`, 3: chances after reset or restart.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: asynchronous active-low reset.
- `ld_x`, in, 1: load `x_out` from `new_x_position`.
- `ld_y`, in, 1: load `y_out` from `new_y_position`.
- `enable`, in, 1: allow horizontal motion.
- `inc_score`, in, 1: increment score.
- `dec_chances`, in, 1: decrement chances.
- `new_x_position`, in, 8: x load value.
- `new_y_position`, in, 7: y load value.
- `o`, out, 1: current block overlaps the placed block below.
- `c`, out, 1: chances != 0.
- `x_out`, out, 8: current block left x.
- `y_out`, out, 7: current block top y.
- `prev_x`, out, 8: left x of the placed block below.
- `score`, out, 4: score, saturating at 15.
- `chances`, out, 4: remaining chances.
- `draw_req`, out, 1: one-cycle redraw strobe.

## Operation
Reset values: `x_out`=0, `y_out`=`BASE_Y`, `prev_x`=0, direction=right, divider=0, `score`=0, `chances`=`INIT_CHANCES`, `draw_req`=0, speed level=0.

- **Motion:** while `enable` and not `ld_x`:
  - The divider counts 0..limit-1. At terminal count it wraps to 0 and `x_out` moves 1 px in the current direction.
  - Ping-pong travel: at `x_out`=`X_MAX`-`BLOCK_W` (144) the direction flips to left, and that tick moves to 143. At 0 it flips to right, and that tick moves to 1.
  - `enable`=0 freezes `x_out` and holds the divider.
- **Load x:** `ld_x` has priority over motion. `x_out` := `new_x_position`, divider := 0, direction := right.
- **Load y, three cases:**
  - Advance (`ld_y` and `new_y_position` != `y_out` and != `BASE_Y`): `prev_x` := old `x_out`, i.e. the pre-load value sampled in the same cycle. Speed level += 1, saturating at 7.
  - Restart (`ld_y` and `new_y_position` == `BASE_Y`): `score` := 0, `chances` := `INIT_CHANCES`, level := 0, `prev_x` := 0. `inc_score`/`dec_chances` are ignored that cycle.
  - Retry (`ld_y` and `new_y_position` == `y_out`, not `BASE_Y`): `prev_x` and level unchanged.
- **Counters:**
  - `inc_score`: `score`+1, saturating at 15.
  - `dec_chances`: `chances`-1, saturating at 0.
  - Both may assert in the same cycle and act independently.
- **Overlap:** `o` = (`x_out`+`BLOCK_W` > `prev_x`) && (`prev_x`+`BLOCK_W` > `x_out`).
  - Evaluated in 9-bit unsigned arithmetic, so there is no wrap.
  - Combinational from registers only; there is no input-to-output combinational path.
- **Chances flag:** `c` = (`chances` != 0), combinational from the register.

## Timing
- All state updates occur on the `clk` rising edge.
- Loads are visible on `x_out`/`y_out` the cycle after `ld_*`.
- `o` and `c` reflect the registers in the same cycle; the FSM samples them one edge later.
- `draw_req`=1 in the cycle after any change of `x_out` or `y_out`, from a load or a move. A load of an identical value produces no strobe.
- The first move after `enable` rises occurs `limit` cycles later. It is also `limit` cycles after an `ld_x`.
- `resetn` low mid-move: all registers take reset values immediately, with no clock required. The first move after release occurs `limit` cycles after release.

## Configuration
- `GAMEPLAY_DP_SPEEDUP_EN` defined: limit = max(1, `TICK_DIV` - level*`SPEED_STEP`). The block speeds up on each advanced row.
- Not defined: limit = `TICK_DIV` always. The level register is still kept but has no effect.

## Test plan
All scenarios use bench parameters `TICK_DIV`=4, `SPEED_STEP`=1, `BLOCK_W`=16, `X_MAX`=160.
- **Reset:** pulse `resetn` low mid-run.
  - Required: `x_out`=0, `y_out`=104, `score`=0, `chances`=3, `c`=1, `draw_req`=0, asynchronously.
- **Bounce:** `enable`=1 continuously from `x_out`=0.
  - Required: `x_out`=1 after 4 cycles.
  - Required: reaches 144 after 576 cycles, then 143 four cycles later.
  - Required: a `draw_req` pulse per move.
- **Advance then overlap:**
  - Set `x_out`=40, then `ld_y` with y=88 and `ld_x` with x=0.
  - Required: `prev_x`=40, `x_out`=0, `o`=0.
  - Move `x_out` to 25: `o`=1. At `x_out`=24: `o`=0. At `x_out`=56: `o`=0. At `x_out`=55: `o`=1.
- **Retry and counters:**
  - Three `ld_y`(y=88) with `dec_chances` and `inc_score`.
  - Required: `prev_x` unchanged, `chances`=0, `c`=0, `score`=3.
  - A fourth `dec_chances` leaves `chances`=0.
- **Restart:** `ld_y` with y=104 plus `inc_score`.
  - Required: `score`=0, `chances`=3, `prev_x`=0.
- **Speedup:** with the macro defined, after 2 advances the move period is 2 cycles; without the macro it stays 4.
